// File: rtl/ultrasonic_echo_emulator.sv
// Purpose: sensor-side stand-in for an ultrasonic ranger; answers a validated trigger with a programmable-width echo.
// Latency: echo rises BURST_DELAY cycles after the trigger falls and stays high W cycles; all outputs registered.
// Backpressure: none; trig_in is ignored while busy (DELAY/ECHO/HOLD), a trigger held high parks the block in TRIG.
//
// Ports:
//   clk        system clock
//   reset_all  asynchronous active-high reset
//   trig_in    trigger from the ranging controller (synchronous to clk)
//   width_in   requested echo width in cycles, sampled when the trigger is accepted
//   echo_out   echo pulse back to the controller
//   busy       high whenever the sequencer is not idle
//   echo_done  one-cycle pulse at echo end
//   short_trig one-cycle pulse when a too-short trigger is rejected
//
// Build option: ECHO_TIMEOUT_EN -- when defined, a zero width ("no object")
// yields a full TIMEOUT_CYCLES echo; otherwise a zero width yields no echo
// and only the echo_done pulse.
module ultrasonic_echo_emulator #(
    parameter int COUNT_W        = 23,
    parameter int TRIG_MIN       = 10,
    parameter int BURST_DELAY    = 8,
    parameter int HOLDOFF        = 16,
    parameter int TIMEOUT_CYCLES = 1900000
) (
    input  logic               clk,
    input  logic               reset_all,
    input  logic               trig_in,
    input  logic [COUNT_W-1:0] width_in,
    output logic               echo_out,
    output logic               busy,
    output logic               echo_done,
    output logic               short_trig
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_DELAY,
        S_ECHO,
        S_HOLD
    } state_t;

    localparam logic [COUNT_W-1:0] ONE_C      = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] TRIG_MIN_C = COUNT_W'(TRIG_MIN);
    localparam logic [COUNT_W-1:0] DELAY_C    = COUNT_W'(BURST_DELAY);
    localparam logic [COUNT_W-1:0] HOLDOFF_C  = COUNT_W'(HOLDOFF);
    localparam logic [COUNT_W-1:0] TIMEOUT_C  = COUNT_W'(TIMEOUT_CYCLES);

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;       // shared phase counter: trigger width, delay, echo, holdoff
    logic [COUNT_W-1:0] w_q, w_d;           // echo width latched at acceptance
    logic [COUNT_W-1:0] w_sel;
    logic               trig_prev_q;
    logic               echo_q, echo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               short_q, short_d;

    // Echo width clamp, evaluated on the live width_in at the acceptance edge.
`ifdef ECHO_TIMEOUT_EN
    assign w_sel = ((width_in == '0) || (width_in > TIMEOUT_C)) ? TIMEOUT_C : width_in;
`else
    assign w_sel = (width_in > TIMEOUT_C) ? TIMEOUT_C : width_in;
`endif

    // Every phase counter is loaded with 1 on entry so that "cnt_q == N"
    // marks the edge exactly N cycles after the entry edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        echo_d  = 1'b0;
        done_d  = 1'b0;
        short_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // prev register runs in every state, so a trigger still high
                // on return to IDLE is not seen as a new edge.
                if (trig_in && !trig_prev_q) begin
                    state_d = S_TRIG;
                    cnt_d   = ONE_C;
                end
            end
            S_TRIG: begin
                if (trig_in) begin
                    if (cnt_q < TRIG_MIN_C) begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end else if (cnt_q >= TRIG_MIN_C) begin
                    w_d     = w_sel;
                    cnt_d   = ONE_C;
                    state_d = S_DELAY;
                end else begin
                    short_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_DELAY: begin
                if (cnt_q == DELAY_C) begin
                    cnt_d = ONE_C;
`ifdef ECHO_TIMEOUT_EN
                    state_d = S_ECHO;
                    echo_d  = 1'b1;
`else
                    // Zero width: skip the echo, still report completion.
                    if (w_q == '0) begin
                        state_d = S_HOLD;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ECHO;
                        echo_d  = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            S_ECHO: begin
                if (cnt_q == w_q) begin
                    state_d = S_HOLD;
                    done_d  = 1'b1;
                    cnt_d   = ONE_C;
                end else begin
                    echo_d = 1'b1;
                    cnt_d  = cnt_q + ONE_C;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLDOFF_C) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset_all) begin
        if (reset_all) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            w_q         <= '0;
            trig_prev_q <= 1'b0;
            echo_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            w_q         <= w_d;
            trig_prev_q <= trig_in;
            echo_q      <= echo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            short_q     <= short_d;
        end
    end

    assign echo_out   = echo_q;
    assign busy       = busy_q;
    assign echo_done  = done_q;
    assign short_trig = short_q;

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Purpose: self-checking bench for ultrasonic_echo_emulator against a timestamp-based reference model.
// Latency: outputs compared every cycle, 1 time unit after the rising clock edge.
// Backpressure: n/a; stimulus driven on the falling edge.
module tb_ultrasonic_echo_emulator;

    localparam int CW   = 23;
    localparam int TMIN = 10;
    localparam int BD   = 8;
    localparam int HO   = 16;
    localparam int TO   = 200;

    logic          clk = 1'b0;
    logic          reset_all;
    logic          trig_in;
    logic [CW-1:0] width_in;
    logic          echo_out;
    logic          busy;
    logic          echo_done;
    logic          short_trig;

    always #5 clk = ~clk;

    ultrasonic_echo_emulator #(
        .COUNT_W        (CW),
        .TRIG_MIN       (TMIN),
        .BURST_DELAY    (BD),
        .HOLDOFF        (HO),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset_all  (reset_all),
        .trig_in    (trig_in),
        .width_in   (width_in),
        .echo_out   (echo_out),
        .busy       (busy),
        .echo_done  (echo_done),
        .short_trig (short_trig)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: each transaction is described by absolute edge
    // numbers (detect, accept/reject, end of holdoff) and outputs are pure
    // functions of the current edge number.
    int t       = 0;
    int idle_at = -1;   // last edge of the current transaction; IDLE evaluates after it
    int det_at  = -1;
    int e0      = 0;
    int weff    = 0;
    int rej_at  = -1;
    bit pend    = 1'b0;
    bit acc     = 1'b0;
    bit prev_m  = 1'b0;

    function automatic int eff_width(input int w);
        if (w == 0) begin
`ifdef ECHO_TIMEOUT_EN
            return TO;
`else
            return 0;
`endif
        end
        return (w > TO) ? TO : w;
    endfunction

    always @(posedge clk) begin
        t++;
        if (reset_all) begin
            pend    = 1'b0;
            acc     = 1'b0;
            det_at  = -1;
            rej_at  = -1;
            idle_at = t;
            prev_m  = 1'b0;
        end else begin
            if (pend) begin
                if (!trig_in) begin
                    pend = 1'b0;
                    if (t - det_at >= TMIN) begin
                        acc     = 1'b1;
                        e0      = t;
                        weff    = eff_width(int'(width_in));
                        idle_at = t + BD + weff + HO;
                    end else begin
                        rej_at  = t;
                        idle_at = t;
                    end
                end
            end else if (t > idle_at && trig_in && !prev_m) begin
                pend   = 1'b1;
                det_at = t;
                acc    = 1'b0;
                rej_at = -1;
            end
            prev_m = trig_in;
        end
    end

    // Per-cycle comparison plus pulse bookkeeping for the directed checks.
    int last_w  = 0;
    int ew      = 0;
    int n_echo  = 0;
    int n_done  = 0;
    int n_short = 0;

    always @(posedge clk) begin
        logic [3:0] exp_v;
        bit         m_echo;
        bit         m_done;
        #1;
        m_echo = acc && (weff > 0) && (t >= e0 + BD) && (t < e0 + BD + weff);
        m_done = acc && (t == e0 + BD + weff);
        exp_v  = reset_all ? 4'b0000
                           : {m_echo, (pend || (t < idle_at)), m_done, (t == rej_at)};
        check_eq("outputs{echo,busy,done,short}", {28'd0, echo_out, busy, echo_done, short_trig},
                 {28'd0, exp_v});
        if (echo_out) begin
            ew++;
        end else if (ew > 0) begin
            last_w = ew;
            ew     = 0;
            n_echo++;
        end
        if (echo_done)  n_done++;
        if (short_trig) n_short++;
    end

    task automatic pulse(input int hi, input int w);
        @(negedge clk);
        trig_in  = 1'b1;
        width_in = CW'(w);
        repeat (hi) @(negedge clk);
        trig_in = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq(tag, {31'd0, ok}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_echo(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (echo_out) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq(tag, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int snap_echo;
        int snap_done;
        int hi;
        int w;

        reset_all = 1'b1;
        trig_in   = 1'b0;
        width_in  = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_state", {28'd0, echo_out, busy, echo_done, short_trig}, 32'd0);
        reset_all = 1'b0;
        repeat (2) @(negedge clk);

        // Nominal 10-cycle trigger, 50-cycle echo
        pulse(10, 50);
        wait_idle("t1_idle");
        check_eq("t1_width", last_w, 50);
        check_eq("t1_done_cnt", n_done, 1);

        // Short trigger rejected, then a 12-cycle trigger accepted
        snap_echo = n_echo;
        pulse(5, 50);
        wait_idle("t2_idle");
        check_eq("t2_short_cnt", n_short, 1);
        check_eq("t2_no_echo", n_echo, snap_echo);
        pulse(12, 30);
        wait_idle("t2b_idle");
        check_eq("t2b_width", last_w, 30);

        // Clamp to timeout, then zero width
        pulse(10, 500);
        wait_idle("t3_idle");
        check_eq("t3_clamp", last_w, TO);
        snap_echo = n_echo;
        snap_done = n_done;
        pulse(10, 0);
        wait_idle("t3z_idle");
        check_eq("t3z_done", n_done, snap_done + 1);
`ifdef ECHO_TIMEOUT_EN
        check_eq("t3z_width", last_w, TO);
`else
        check_eq("t3z_no_echo", n_echo, snap_echo);
`endif

        // Triggers during ECHO and held through HOLD into IDLE are ignored
        pulse(10, 60);
        wait_echo("t4_rise");
        repeat (5) @(negedge clk);
        trig_in = 1'b1;
        repeat (10) @(negedge clk);
        trig_in = 1'b0;
        repeat (5) @(negedge clk);
        trig_in = 1'b1;
        wait_idle("t4_idle");
        repeat (10) @(negedge clk);
        check_eq("t4_held_busy", {31'd0, busy}, 32'd0);
        check_eq("t4_width", last_w, 60);
        trig_in = 1'b0;
        pulse(10, 20);
        wait_idle("t4b_idle");
        check_eq("t4b_width", last_w, 20);

        // width_in changed after acceptance has no effect
        pulse(10, 50);
        @(negedge clk);
        width_in = CW'(7);
        wait_idle("t5_idle");
        check_eq("t5_width", last_w, 50);

        // Asynchronous reset mid-echo
        pulse(10, 50);
        wait_echo("t6_rise");
        repeat (19) @(negedge clk);
        #2 reset_all = 1'b1;
        #1;
        check_eq("t6_async_echo", {31'd0, echo_out}, 32'd0);
        check_eq("t6_async_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        reset_all = 1'b0;
        repeat (2) @(negedge clk);
        pulse(10, 30);
        wait_idle("t6b_idle");
        check_eq("t6b_width", last_w, 30);

        // Long trigger: counter saturates, still accepted on fall
        pulse(40, 10);
        wait_idle("t7_idle");
        check_eq("t7_width", last_w, 10);

        // Randomized triggers, widths and stray trigger activity
        for (int k = 0; k < 25; k++) begin
            hi = int'($urandom_range(3, 14));
            w  = int'($urandom_range(0, 260));
            pulse(hi, w);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 30)) @(negedge clk);
                trig_in = 1'b1;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                trig_in = 1'b0;
            end
            wait_idle("rnd_idle");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ultrasonic_echo_emulator.md
# ultrasonic_echo_emulator

Synthesizable model of the ultrasonic range sensor: the sensor end of the trigger/echo interface that the ranging controller drives. It accepts the controller's trigger pulse, validates its width, waits a fixed burst delay, then drives an echo pulse whose width in clock cycles is set by a programmable distance value. It serves as the sensor stand-in for on-board loopback and for closed-loop simulation of the ranging controller.

## Interface
Parameters:
- COUNT_W, 23, width of echo-width datapath (matches controller count width)
- TRIG_MIN, 10, minimum trigger high time in cycles for acceptance
- BURST_DELAY, 8, cycles from trigger acceptance to echo rise (≥1)
- HOLDOFF, 16, cycles after echo fall during which triggers are ignored (≥1)
- TIMEOUT_CYCLES, 1900000, maximum echo width (38 ms at 50 MHz); must fit in COUNT_W

Ports:
- clk  in  1  system clock
- reset_all  in  1  asynchronous, active-high reset
- trig_in  in  1  trigger from ranging controller pulse output; synchronous to clk
- width_in  in  COUNT_W  requested echo width in cycles; sampled at trigger acceptance
- echo_out  out  1  echo to ranging controller echo input
- busy  out  1  high whenever state ≠ IDLE
- echo_done  out  1  one-cycle pulse at echo end
- short_trig  out  1  one-cycle pulse when a trigger shorter than TRIG_MIN is rejected

## Operation
- States: IDLE, TRIG, DELAY, ECHO, HOLD.
- IDLE: trig_in low→high (registered previous value low, current high) → TRIG, trigger counter = 1. trig_in already high on entry to IDLE is not a rising edge.
- TRIG: counter increments while trig_in high, saturating at TRIG_MIN. On trig_in low: counter ≥ TRIG_MIN → latch W, → DELAY; else pulse short_trig, → IDLE.
- W = min(width_in, TIMEOUT_CYCLES); comparison unsigned, full COUNT_W.
- DELAY: count BURST_DELAY cycles, → ECHO with echo_out high.
- ECHO: echo_out high exactly W cycles, then low, echo_done pulse, → HOLD.
- HOLD: count HOLDOFF cycles, → IDLE.
- trig_in ignored in DELAY, ECHO, HOLD; width_in changes after latch have no effect on current echo.
- W = 0: see Configuration.

## Timing
- Reset values: echo_out 0, busy 0, echo_done 0, short_trig 0, state IDLE, all counters 0, previous-trig register 0. Reset mid-operation (including mid-echo) drops echo_out immediately (async) and returns to IDLE.
- All outputs registered.
- Edge E0 = clock edge at which trig_in low is sampled in TRIG. busy high from the edge after rising-edge detection through the end of HOLD.
- echo_out rises at edge E0+BURST_DELAY, falls at E0+BURST_DELAY+W; echo_done high for the cycle following that falling edge.
- State returns to IDLE at edge E0+BURST_DELAY+W+HOLDOFF; earliest new rising edge detected at the following edge.
- short_trig high for the one cycle after E0 on rejection.
- Trigger held high indefinitely: stays in TRIG, no echo, busy high.

## Configuration
- ECHO_TIMEOUT_EN defined: W = 0 ("no object") produces echo of TIMEOUT_CYCLES cycles, matching the real sensor's no-return behaviour.
- ECHO_TIMEOUT_EN undefined: W = 0 produces no echo; DELAY → HOLD directly, echo_out stays 0, echo_done pulses once at the edge where ECHO would have started.

## Test plan
- trig_in high 10 cycles, width_in = 50 → echo_out rises 8 edges after trig fall, high exactly 50 cycles, echo_done single pulse, busy low 16 cycles after echo fall.
- trig_in high 5 cycles → short_trig one pulse, echo_out stays 0, back to IDLE; next 12-cycle trigger accepted normally.
- TIMEOUT_CYCLES = 200 override, width_in = 500 → echo 200 cycles; width_in = 0 → 200-cycle echo with ECHO_TIMEOUT_EN, no echo and one echo_done without.
- Second trigger pulse during ECHO and trig_in held high through HOLD into IDLE → both ignored; echo width unchanged; new echo only after trig_in goes low then high again.
- width_in changed from 50 to 7 one cycle after acceptance → echo still 50 cycles.
- reset_all asserted 20 cycles into a 50-cycle echo → echo_out low without waiting for clk edge, busy 0; after release, 10-cycle trigger with width 30 → normal 30-cycle echo.
